// File: rtl/mod_updown_counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo up/down counter family.
//   CNT_MODE_WRAP / CNT_MODE_SAT : values for the SATURATE parameter
//   cnt_terminal(up, modulo)     : count value at which the next step in the
//                                  given direction wraps or saturates
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int unsigned CNT_MODE_WRAP = 0;
    localparam int unsigned CNT_MODE_SAT  = 1;

    // Terminal value is MODULO-1 when counting up, 0 when counting down.
    function automatic int unsigned cnt_terminal(input logic up, input int unsigned modulo);
        return up ? (modulo - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/mod_updown_counter_step.sv
// ----------------------------------------------------------------------------
// mod_step
// Combinational next-count logic for one modulo up/down counter stage.
//   q        in   WIDTH  current count
//   up       in   1      1: increment, 0: decrement
//   next_q   out  WIDTH  count after one enabled step
//   at_limit out  1      q equals the terminal value for the current direction
// ----------------------------------------------------------------------------
module mod_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 16,
    parameter int unsigned SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             at_limit
);

    // MODULO may equal 2**WIDTH, so MODULO-1 is formed one bit wider and
    // then narrowed; the result always fits in WIDTH bits.
    localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] MAX_Q  = MOD_M1[WIDTH-1:0];

    logic [WIDTH-1:0] term;

    always_comb begin
        term     = WIDTH'(cnt_terminal(up, MODULO));
        at_limit = (q == term);
        next_q   = q;
        if (at_limit) begin
            if (SATURATE == CNT_MODE_SAT) begin
                next_q = q;
            end else begin
                next_q = up ? '0 : MAX_Q;
            end
        end else begin
            next_q = up ? (q + 1'b1) : (q - 1'b1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
// WIDTH-bit modulo-MODULO up/down counter with synchronous load, enable,
// wrap/saturate mode, cascade carry and a sticky overflow flag.
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-low
//   en         in   1      count enable, one step per enabled cycle
//   up         in   1      1: increment, 0: decrement
//   load       in   1      synchronous load request (overrides en)
//   load_val   in   WIDTH  value to load, clamped to MODULO-1
//   ovf_clr    in   1      clears ovf at the next edge (a set event wins)
//   q          out  WIDTH  current count, registered
//   carry_out  out  1      en & (q at terminal value), combinational
//   ovf        out  1      sticky flag, set on every wrap or saturate event
// ----------------------------------------------------------------------------
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 16,
    parameter int unsigned SATURATE = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             ovf
);

    localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MODULO - 1);

    logic [WIDTH-1:0] next_q;
    logic             at_limit;
    logic [WIDTH-1:0] load_q;

    mod_step #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_step (
        .q        (q),
        .up       (up),
        .next_q   (next_q),
        .at_limit (at_limit)
    );

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        if ({1'b0, load_val} > MOD_M1) begin
            load_q = MOD_M1[WIDTH-1:0];
        end else begin
            load_q = load_val;
        end
    end

    // Independent of load and of SATURATE so cascades behave identically.
    assign carry_out = en & at_limit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= load_q;
            ovf <= ovf & ~ovf_clr;
        end else if (en) begin
            q   <= next_q;
            ovf <= at_limit | (ovf & ~ovf_clr);
        end else begin
            ovf <= ovf & ~ovf_clr;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       ovf_clr = 1'b0;

    logic [3:0] q_w, q_s, q_m;
    logic       c_w, c_s, c_m;
    logic       o_w, o_s, o_m;

    // Cascade pair
    logic       crst = 1'b0;
    logic       cen = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       c_lo, c_hi;
    logic       o_lo, o_hi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .q(q_w), .carry_out(c_w), .ovf(o_w)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .q(q_s), .carry_out(c_s), .ovf(o_s)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0)) dut_m16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .q(q_m), .carry_out(c_m), .ovf(o_m)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) dut_lo (
        .clk(clk), .rst(crst), .en(cen), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .ovf_clr(1'b0), .q(q_lo), .carry_out(c_lo), .ovf(o_lo)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) dut_hi (
        .clk(clk), .rst(crst), .en(c_lo), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .ovf_clr(1'b0), .q(q_hi), .carry_out(c_hi), .ovf(o_hi)
    );

    typedef struct {
        logic [1:0] sel;     // 0: wrap M=10, 1: saturate M=10, 2: wrap M=16
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] lv;
        logic       clr;
        logic       chk_c;   // carry_out checked before the edge
        logic       c;
        logic [3:0] q;       // expected after the edge
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] sel, input logic r, input logic e, input logic u,
                       input logic ld, input logic [3:0] lv, input logic clr,
                       input logic chk_c, input logic c, input logic [3:0] eq, input logic eo);
        vec_t v;
        v.sel = sel; v.rst = r; v.en = e; v.up = u; v.ld = ld; v.lv = lv; v.clr = clr;
        v.chk_c = chk_c; v.c = c; v.q = eq; v.ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [3:0] sq;
    logic       sc, so;
    int         elo, ehi;

    initial begin
        // T1: reset held with load/en active
        //  sel r  e  u  ld lv  clr chk c  q  ovf
        add(0, 0, 1, 1, 1, 7,  0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 7,  0, 1, 0, 0, 0);
        // T2: count up 12 cycles, wrap 9 -> 0
        for (int k = 0; k < 12; k++) begin
            automatic int pre = k % 10;
            add(0, 1, 1, 1, 0, 0, 0, 1, (pre == 9), 4'((pre + 1) % 10), (k >= 9));
        end
        // T3: load beats enable, then clamp
        add(0, 1, 1, 1, 1, 3,  0, 1, 0, 3, 1);
        add(0, 1, 1, 1, 1, 12, 0, 1, 0, 9, 1);
        add(0, 1, 0, 1, 0, 0,  0, 1, 0, 9, 1);   // en=0 at q=9: no carry, hold
        add(0, 1, 0, 1, 0, 0,  1, 1, 0, 9, 0);   // clear
        // T5: wrap and clear in the same cycle: set wins
        add(0, 1, 1, 1, 0, 0,  1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0,  0, 1, 1, 9, 1);   // down wrap 0 -> 9
        add(0, 1, 1, 0, 1, 5,  1, 1, 0, 5, 0);   // load + clear, no set
        add(0, 1, 1, 0, 0, 0,  0, 1, 0, 4, 0);
        add(0, 1, 1, 1, 0, 0,  0, 1, 0, 5, 0);   // direction change
        add(0, 1, 0, 1, 1, 10, 0, 1, 0, 9, 0);   // load_val == MODULO clamps
        add(0, 1, 1, 1, 1, 15, 0, 1, 1, 9, 0);   // carry independent of load
        add(0, 1, 1, 1, 0, 0,  0, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0,  0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 1, 5,  0, 1, 0, 0, 0);   // mid-count reset
        add(0, 1, 1, 0, 0, 0,  0, 1, 1, 9, 1);
        // T4: saturate mode
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1);
        add(1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 8,  0, 1, 0, 8, 0);
        add(1, 1, 1, 1, 0, 0,  0, 1, 0, 9, 0);
        add(1, 1, 1, 1, 0, 0,  0, 1, 1, 9, 1);
        add(1, 1, 1, 1, 0, 0,  1, 1, 1, 9, 1);
        add(1, 1, 1, 0, 0, 0,  0, 1, 0, 8, 1);
        // MODULO = 2**WIDTH
        add(2, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        add(2, 1, 0, 1, 1, 15, 0, 1, 0, 15, 0);
        add(2, 1, 1, 1, 0, 0,  0, 1, 1, 0,  1);
        add(2, 1, 1, 0, 0, 0,  0, 1, 1, 15, 1);
        add(2, 1, 1, 0, 0, 0,  1, 1, 0, 14, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; up = tbl[i].up;
            load = tbl[i].ld; load_val = tbl[i].lv; ovf_clr = tbl[i].clr;
            #1;
            case (tbl[i].sel)
                2'd0:    sc = c_w;
                2'd1:    sc = c_s;
                default: sc = c_m;
            endcase
            if (tbl[i].chk_c) check($sformatf("vec%0d carry_out", i), {7'd0, sc}, {7'd0, tbl[i].c});
            @(posedge clk);
            #1;
            case (tbl[i].sel)
                2'd0:    begin sq = q_w; so = o_w; end
                2'd1:    begin sq = q_s; so = o_s; end
                default: begin sq = q_m; so = o_m; end
            endcase
            check($sformatf("vec%0d q", i), {4'd0, sq}, {4'd0, tbl[i].q});
            check($sformatf("vec%0d ovf", i), {7'd0, so}, {7'd0, tbl[i].ovf});
        end

        // T6: cascade, 100 enables returns both stages to 0
        @(negedge clk);
        crst = 1'b0; cen = 1'b0;
        @(posedge clk); #1;
        check("cascade reset lo", {4'd0, q_lo}, 8'd0);
        check("cascade reset hi", {4'd0, q_hi}, 8'd0);
        elo = 0; ehi = 0;
        for (int k = 0; k < 137; k++) begin
            @(negedge clk);
            crst = 1'b1; cen = 1'b1;
            #1;
            check($sformatf("cascade%0d hi carry", k), {7'd0, c_hi}, {7'd0, (elo == 9 && ehi == 9)});
            @(posedge clk); #1;
            if (elo == 9) begin
                elo = 0;
                ehi = (ehi == 9) ? 0 : ehi + 1;
            end else begin
                elo = elo + 1;
            end
            check($sformatf("cascade%0d lo", k), {4'd0, q_lo}, 8'(elo));
            check($sformatf("cascade%0d hi", k), {4'd0, q_hi}, 8'(ehi));
            if (k == 99) begin
                check("cascade 100 lo", {4'd0, q_lo}, 8'd0);
                check("cascade 100 hi", {4'd0, q_hi}, 8'd0);
            end
        end
        // Now at 37: reset with enable still high zeroes both stages
        @(negedge clk);
        crst = 1'b0; cen = 1'b1;
        @(posedge clk); #1;
        check("cascade midreset lo", {4'd0, q_lo}, 8'd0);
        check("cascade midreset hi", {4'd0, q_hi}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
